// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: turns the core's instruction-fetch and data SRAM-style ports
// into one AXI3 master. Only one AXI transaction is in flight at a time, so
// responses return in the order requests were accepted. Data requests win
// arbitration over instruction fetches.
module cpu_axi_bridge (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_AW_W,
        WR_B
    } state_t;

    state_t      state;
    state_t      state_next;

    // Holding registers for the one transaction in flight
    logic        src_data;
    logic        wr_hold;
    logic [1:0]  size_hold;
    logic [3:0]  wstrb_hold;
    logic [31:0] addr_hold;
    logic [31:0] wdata_hold;
    logic        aw_done;
    logic        w_done;

    logic        accept_data;
    logic        accept_inst;
    logic        aw_hs;
    logic        w_hs;

    // Responses are routed by the latched source, never by ID, and errors are
    // not acted upon, so these inputs are intentionally left unconsumed.
    logic        unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

    assign accept_data = (state == IDLE) && data_sram_req && !reset;
    assign accept_inst = (state == IDLE) && inst_sram_req && !data_sram_req && !reset;

    assign data_sram_addr_ok = accept_data;
    assign inst_sram_addr_ok = accept_inst;

    assign inst_sram_rdata = rdata;
    assign data_sram_rdata = rdata;

    assign arid    = {3'b000, src_data};
    assign araddr  = addr_hold;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_hold};
    assign arburst = 2'b01;

    // The only writer is the data port, so awid follows the latched source
    // and therefore reads 0 straight out of reset.
    assign awid    = {3'b000, src_data};
    assign awaddr  = addr_hold;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_hold};
    assign awburst = 2'b01;

    assign wdata   = wdata_hold;
    assign wstrb   = wstrb_hold;
    assign wlast   = 1'b1;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the accepted request and remember which write handshakes are done
    always_ff @(posedge clk) begin
        if (reset) begin
            src_data   <= 1'b0;
            wr_hold    <= 1'b0;
            size_hold  <= 2'd0;
            wstrb_hold <= 4'h0;
            addr_hold  <= 32'h0;
            wdata_hold <= 32'h0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            if (accept_data) begin
                src_data   <= 1'b1;
                wr_hold    <= data_sram_wr;
                size_hold  <= data_sram_size;
                wstrb_hold <= data_sram_wstrb;
                addr_hold  <= data_sram_addr;
                wdata_hold <= data_sram_wdata;
            end else if (accept_inst) begin
                src_data   <= 1'b0;
                wr_hold    <= 1'b0;
                size_hold  <= 2'd2;
                wstrb_hold <= 4'h0;
                addr_hold  <= inst_sram_addr;
                wdata_hold <= 32'h0;
            end
            if (accept_data || accept_inst) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_done <= 1'b1;
                end
                if (w_hs) begin
                    w_done <= 1'b1;
                end
            end
        end
    end

    // Next-state and channel handshake outputs
    always_comb begin
        state_next        = state;
        arvalid           = 1'b0;
        rready            = 1'b0;
        awvalid           = 1'b0;
        wvalid            = 1'b0;
        bready            = 1'b0;
        inst_sram_data_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        case (state)
            IDLE: begin
                if (accept_data) begin
                    state_next = data_sram_wr ? WR_AW_W : RD_AR;
                end else if (accept_inst) begin
                    state_next = RD_AR;
                end
            end
            RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = RD_R;
                end
            end
            RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (src_data) begin
                        data_sram_data_ok = 1'b1;
                    end else begin
                        inst_sram_data_ok = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            WR_AW_W: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) begin
                    state_next = WR_B;
                end
            end
            WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_sram_data_ok = 1'b1;
                    state_next        = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed and randomized checks of cpu_axi_bridge against a
// transaction-level model of the bridge plus a simple AXI slave.
module tb_cpu_axi_bridge;

    logic        clk;
    logic        reset;

    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    // Slave behaviour knobs, set per cycle by the stimulus
    logic        k_arready, k_rgo, k_awready, k_wready, k_bgo, k_stray;
    logic [31:0] k_rdata;

    // Transaction-level model: what the bridge still owes on the AXI side
    logic        busy, ar_owed, r_owed, aw_owed, w_owed, b_owed;
    logic        t_src, t_wr;
    logic [1:0]  t_size;
    logic [3:0]  t_wstrb;
    logic [31:0] t_addr, t_wdata, rd_data;
    logic        acc_inst, acc_data;
    logic [31:0] last_rdata;
    int          cyc, acc_cyc, idok_cyc, ddok_cyc;

    int          checks, passes, fails;

    cpu_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic resetModel();
        busy = 0; ar_owed = 0; r_owed = 0; aw_owed = 0; w_owed = 0; b_owed = 0;
        t_src = 0; t_wr = 0; t_size = 0; t_wstrb = 0; t_addr = 0; t_wdata = 0;
        rd_data = 0;
    endtask

    // One clock cycle: drive slave inputs, check at negedge, advance the model
    task automatic applyStimulus();
        logic exp_iaok, exp_daok, exp_idok, exp_ddok, w_phase;
        arready = k_arready;
        awready = k_awready;
        wready  = k_wready;
        rvalid  = (r_owed && k_rgo) || k_stray;
        rdata   = rd_data;
        rid     = {3'b000, t_src};
        rresp   = 2'($urandom_range(0, 3));
        rlast   = 1'b1;
        bvalid  = b_owed && k_bgo;
        bid     = 4'd1;
        bresp   = 2'($urandom_range(0, 3));
        @(negedge clk);
        acc_inst = 0;
        acc_data = 0;
        if (reset) begin
            resetModel();
        end else begin
            exp_daok = data_sram_req && !busy;
            exp_iaok = inst_sram_req && !data_sram_req && !busy;
            exp_idok = r_owed && rvalid && !t_src;
            exp_ddok = (r_owed && rvalid && t_src) || (b_owed && bvalid);
            checkOutput("data_addr_ok", 32'(data_sram_addr_ok), 32'(exp_daok));
            checkOutput("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(exp_iaok));
            checkOutput("inst_data_ok", 32'(inst_sram_data_ok), 32'(exp_idok));
            checkOutput("data_data_ok", 32'(data_sram_data_ok), 32'(exp_ddok));
            checkOutput("arvalid", 32'(arvalid), 32'(ar_owed));
            checkOutput("rready", 32'(rready), 32'(r_owed));
            checkOutput("awvalid", 32'(awvalid), 32'(aw_owed));
            checkOutput("wvalid", 32'(wvalid), 32'(w_owed));
            checkOutput("bready", 32'(bready), 32'(b_owed));
            if (ar_owed) begin
                checkOutput("araddr", araddr, t_addr);
                checkOutput("arid", 32'(arid), 32'(t_src));
                checkOutput("arsize", 32'(arsize), 32'(t_size));
                checkOutput("arlen", 32'(arlen), 32'd0);
                checkOutput("arburst", 32'(arburst), 32'd1);
            end
            if (aw_owed) begin
                checkOutput("awaddr", awaddr, t_addr);
                checkOutput("awid", 32'(awid), 32'd1);
                checkOutput("awsize", 32'(awsize), 32'(t_size));
                checkOutput("awlen", 32'(awlen), 32'd0);
                checkOutput("awburst", 32'(awburst), 32'd1);
            end
            if (w_owed) begin
                checkOutput("wdata", wdata, t_wdata);
                checkOutput("wstrb", 32'(wstrb), 32'(t_wstrb));
                checkOutput("wlast", 32'(wlast), 32'd1);
            end
            if (exp_idok) begin
                checkOutput("inst_rdata", inst_sram_rdata, rd_data);
                last_rdata = rd_data;
                idok_cyc = cyc;
            end
            if (exp_ddok) begin
                ddok_cyc = cyc;
                if (!t_wr) begin
                    checkOutput("data_rdata", data_sram_rdata, rd_data);
                    last_rdata = rd_data;
                end
            end
            // Advance the model by this cycle's handshakes
            w_phase = aw_owed || w_owed;
            if (ar_owed && arready) begin
                ar_owed = 0;
                r_owed  = 1;
                rd_data = k_rdata;
            end else if (r_owed && rvalid) begin
                r_owed = 0;
                busy   = 0;
            end
            if (aw_owed && awready) aw_owed = 0;
            if (w_owed && wready) w_owed = 0;
            if (b_owed && bvalid) begin
                b_owed = 0;
                busy   = 0;
            end
            if (w_phase && !aw_owed && !w_owed) b_owed = 1;
            if (exp_daok || exp_iaok) begin
                busy    = 1;
                acc_cyc = cyc;
                if (exp_daok) begin
                    acc_data = 1;
                    t_src = 1; t_wr = data_sram_wr; t_size = data_sram_size;
                    t_wstrb = data_sram_wstrb; t_addr = data_sram_addr; t_wdata = data_sram_wdata;
                end else begin
                    acc_inst = 1;
                    t_src = 0; t_wr = 0; t_size = 2'd2;
                    t_wstrb = 4'h0; t_addr = inst_sram_addr; t_wdata = 32'h0;
                end
                if (t_wr) begin
                    aw_owed = 1;
                    w_owed  = 1;
                end else begin
                    ar_owed = 1;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    task automatic allReady();
        k_arready = 1; k_rgo = 1; k_awready = 1; k_wready = 1; k_bgo = 1; k_stray = 0;
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0; cyc = 0;
        acc_cyc = 0; idok_cyc = 0; ddok_cyc = 0; last_rdata = 0;
        inst_sram_req = 0; inst_sram_addr = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0;
        data_sram_wstrb = 0; data_sram_addr = 0; data_sram_wdata = 0;
        allReady();
        k_rdata = 0;
        resetModel();
        reset = 1;
        @(posedge clk);
        #1;
        applyStimulus();
        applyStimulus();
        reset = 0;

        $display("[TB] reset values");
        applyStimulus();
        checkOutput("rst_arid", 32'(arid), 32'd0);
        checkOutput("rst_awid", 32'(awid), 32'd0);
        checkOutput("rst_araddr", araddr, 32'd0);
        checkOutput("rst_awaddr", awaddr, 32'd0);

        $display("[TB] instruction fetch");
        k_rdata = 32'h02800C0C;
        inst_sram_req = 1; inst_sram_addr = 32'h1C000000;
        applyStimulus();
        inst_sram_req = 0;
        checkOutput("fetch_arid", 32'(arid), 32'd0);
        checkOutput("fetch_arsize", 32'(arsize), 32'd2);
        waitIdle("fetch_timeout", 20);
        checkOutput("fetch_latency", 32'(idok_cyc - acc_cyc), 32'd2);
        checkOutput("fetch_rdata", last_rdata, 32'h02800C0C);

        $display("[TB] simultaneous inst and data requests");
        k_rdata = 32'h000000A5;
        inst_sram_req = 1; inst_sram_addr = 32'h1C000004;
        data_sram_req = 1; data_sram_wr = 0; data_sram_size = 0; data_sram_addr = 32'h80;
        applyStimulus();
        data_sram_req = 0;
        checkOutput("arb_arid", 32'(arid), 32'd1);
        checkOutput("arb_arsize", 32'(arsize), 32'd0);
        for (int n = 0; n < 20 && !acc_inst; n++) applyStimulus();
        inst_sram_req = 0;
        checkOutput("arb_inst_after_data", 32'(acc_cyc - ddok_cyc), 32'd1);
        waitIdle("arb_timeout", 20);

        $display("[TB] store with delayed wready");
        k_wready = 0;
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2;
        data_sram_addr = 32'h100; data_sram_wdata = 32'hDEADBEEF; data_sram_wstrb = 4'hF;
        applyStimulus();
        data_sram_req = 0;
        applyStimulus();
        checkOutput("st_awvalid_drop", 32'(awvalid), 32'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("st_wvalid_hold", 32'(wvalid), 32'd1);
        k_wready = 1;
        waitIdle("st_timeout", 20);
        checkOutput("st_latency", 32'(ddok_cyc - acc_cyc), 32'd5);

        $display("[TB] load after store held in response phase");
        k_bgo = 0;
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = 1;
        data_sram_addr = 32'h100; data_sram_wdata = 32'h12345678; data_sram_wstrb = 4'h3;
        applyStimulus();
        data_sram_req = 0;
        applyStimulus();
        data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2; k_rdata = 32'h00005678;
        for (int n = 0; n < 3; n++) applyStimulus();
        checkOutput("raw_load_blocked", 32'(data_sram_addr_ok), 32'd0);
        k_bgo = 1;
        for (int n = 0; n < 20 && !acc_data; n++) applyStimulus();
        data_sram_req = 0;
        checkOutput("raw_order", 32'(acc_cyc - ddok_cyc), 32'd1);
        checkOutput("raw_araddr", araddr, 32'h100);
        waitIdle("raw_timeout", 20);

        $display("[TB] arready stall");
        k_arready = 0; k_rdata = 32'hCAFE0001;
        inst_sram_req = 1; inst_sram_addr = 32'h1C000100;
        applyStimulus();
        inst_sram_req = 0;
        data_sram_req = 1; data_sram_wr = 0; data_sram_size = 1; data_sram_addr = 32'h202;
        for (int n = 0; n < 5; n++) applyStimulus();
        checkOutput("stall_arvalid", 32'(arvalid), 32'd1);
        checkOutput("stall_araddr", araddr, 32'h1C000100);
        checkOutput("stall_no_data_ok", 32'(data_sram_addr_ok), 32'd0);
        k_arready = 1;
        for (int n = 0; n < 20 && !acc_data; n++) applyStimulus();
        data_sram_req = 0;
        waitIdle("stall_timeout", 20);

        $display("[TB] reset during read data phase");
        k_rgo = 0;
        data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2; data_sram_addr = 32'h300;
        applyStimulus();
        data_sram_req = 0;
        applyStimulus();
        checkOutput("rr_in_read", 32'(rready), 32'd1);
        reset = 1;
        applyStimulus();
        reset = 0;
        k_rgo = 1; k_stray = 1;
        applyStimulus();
        checkOutput("rr_stray_data_ok", 32'(data_sram_data_ok), 32'd0);
        checkOutput("rr_rready", 32'(rready), 32'd0);
        checkOutput("rr_araddr", araddr, 32'd0);
        k_stray = 0;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (!inst_sram_req && $urandom_range(0, 2) == 0) begin
                inst_sram_req  = 1;
                inst_sram_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!data_sram_req && $urandom_range(0, 2) == 0) begin
                data_sram_req   = 1;
                data_sram_wr    = 1'($urandom_range(0, 1));
                data_sram_size  = 2'($urandom_range(0, 2));
                data_sram_wstrb = 4'($urandom_range(0, 15));
                data_sram_addr  = $urandom();
                data_sram_wdata = $urandom();
            end
            k_arready = 1'($urandom_range(0, 1));
            k_rgo     = 1'($urandom_range(0, 1));
            k_awready = 1'($urandom_range(0, 1));
            k_wready  = 1'($urandom_range(0, 1));
            k_bgo     = 1'($urandom_range(0, 1));
            k_rdata   = $urandom();
            applyStimulus();
            if (acc_inst) inst_sram_req = 0;
            if (acc_data) data_sram_req = 0;
        end
        inst_sram_req = 0;
        data_sram_req = 0;
        allReady();
        waitIdle("drain_timeout", 20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Converts the core's two request/response SRAM-style ports (instruction fetch, data access) into a single AXI3 master toward the SoC crossbar. It sits directly downstream of the CPU top, replacing the fixed-latency SRAM hookup. It arbitrates between the two ports and runs exactly one AXI transaction at a time, which keeps each port's responses in order. Data requests have priority over instruction fetches.

## Interface
- No parameters. IDs are fixed: inst read = 0, data read/write = 1.
- clk  in  1  core clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- inst_sram_req  in  1  fetch request (read-only, word size).
- inst_sram_addr  in  32  fetch address.
- inst_sram_addr_ok  out  1  fetch request accepted this cycle.
- inst_sram_data_ok  out  1  fetch data valid this cycle.
- inst_sram_rdata  out  32  fetch data.
- data_sram_req  in  1  data request.
- data_sram_wr  in  1  1 = write, 0 = read.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word.
- data_sram_wstrb  in  4  byte enables for a write.
- data_sram_addr / data_sram_wdata  in  32 each  address and write data.
- data_sram_addr_ok / data_sram_data_ok  out  1 each  data accept and data response.
- data_sram_rdata  out  32  load data.
- arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arvalid  out; arready  in.
- rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid  in; rready  out.
- awid[3:0], awaddr[31:0], awlen[7:0], awsize[2:0], awburst[1:0], awvalid  out; awready  in.
- wdata[31:0], wstrb[3:0], wlast, wvalid  out; wready  in.
- bid[3:0], bresp[1:0], bvalid  in; bready  out.

## Operation
- FSM states:
  - IDLE
  - RD_AR: arvalid=1
  - RD_R: rready=1
  - WR_AW_W: awvalid and/or wvalid pending
  - WR_B: bready=1
- Accept rules in IDLE:
  - data_sram_addr_ok = data_sram_req.
  - inst_sram_addr_ok = inst_sram_req && !data_sram_req.
  - Both addr_ok signals are 0 outside IDLE.
- On accept, latch the request into holding registers:
  - source (inst/data), wr, size, wstrb, addr, wdata.
  - inst size is forced to 2.
- Next state after accept: RD_AR for a read, WR_AW_W for a write.
- Constant AXI fields:
  - arlen = awlen = 0, arburst = awburst = 1, wlast = 1.
  - arsize = awsize = {1'b0, size}.
  - arid = 0 for inst, 1 for data; awid = 1.
  - araddr, awaddr, wdata and wstrb come from the holding registers.
- RD_AR: hold arvalid until arready, then go to RD_R.
- RD_R: rready = 1. On rvalid:
  - pulse data_ok of the latched source for one cycle; rdata passes through combinationally.
  - go to IDLE.
  - rid is not used for routing.
- WR_AW_W:
  - awvalid and wvalid rise together on entry.
  - Each drops independently after its own handshake, tracked by aw_done / w_done flags.
  - Go to WR_B once both handshakes are complete, including the case where both complete in the same cycle.
- WR_B: bready = 1. On bvalid, pulse data_sram_data_ok for one cycle and go to IDLE.
- rresp and bresp are ignored; responses are never retried.
- Because only one transaction is in flight, responses come back in the order requests were accepted. This is also the read-after-write ordering rule.

## Timing
- Reset values:
  - FSM = IDLE.
  - arvalid, rready, awvalid, wvalid, bready, both addr_ok and both data_ok = 0.
  - Holding registers = 0, so arid / awid / addresses read as 0.
- addr_ok is combinational from req and state. A request is accepted in the same cycle it is presented if the FSM is in IDLE.
- Read with a zero-wait slave:
  - accept at T, arvalid at T+1 (arready at T+1).
  - rready at T+2, rvalid at T+2, data_ok at T+2.
  - IDLE at T+3, so the next accept is possible at T+3.
- Write with a zero-wait slave:
  - accept at T, aw/w at T+1, bready at T+2.
  - bvalid at T+2 gives data_ok at T+2.
- addr_ok is never asserted in the same cycle as data_ok.
- AXI valids stay asserted and their payloads stay stable until the matching ready is seen.
- Reset asserted mid-transaction: next cycle returns IDLE with all outputs at their reset values; the abandoned AXI transaction is not completed.

## Test plan
- Inst fetch 0x1C000000, arready/rvalid immediate, rdata 0x02800C0C:
  - inst_sram_addr_ok at T, arid = 0, arsize = 2.
  - inst_sram_data_ok at T+2 with rdata 0x02800C0C.
- inst_req and data_req (read 0x80, size 0) in the same cycle:
  - data is accepted first (arid = 1, arsize = 0).
  - inst_sram_addr_ok is held 0 until the data read completes.
  - inst is accepted the cycle after the data read returns to IDLE.
- Store word to 0x100, wdata 0xDEADBEEF, wstrb 0xF; awready at T+1, wready delayed to T+4:
  - awvalid drops at T+2; wvalid holds through T+4.
  - bready from T+5; data_ok on bvalid.
- Store to 0x100, then load from 0x100 requested while the store is in WR_B:
  - load addr_ok stays 0 until the store's data_ok.
  - load arvalid appears only after bvalid.
- arready stalled 5 cycles: arvalid, araddr and arid stay stable throughout; no addr_ok on either port during the stall.
- Reset pulsed while in RD_R:
  - next cycle all valids, readies and oks are 0 and the FSM is IDLE.
  - a stray rvalid after reset produces no data_ok.
